// File: rtl/load_value_spec_unit_if.sv
`default_nettype none
// =============================================================================
// load_value_spec_unit_if : lookup / predict / resolve / recover bundle
// Rev 1.0
// =============================================================================
interface load_value_spec_unit_if #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_INFLIGHT = 4
);
  localparam int C_CNT_W = $clog2(MAX_INFLIGHT) + 1;

  logic               lookup_valid;
  logic [ADDR_W-1:0]  lookup_pc;
  logic [ADDR_W-1:0]  lookup_ckpt_pc;
  logic               lookup_ready;
  logic               pred_valid;
  logic [DATA_W-1:0]  pred_data;
  logic               resolve_valid;
  logic [DATA_W-1:0]  resolve_data;
  logic               recover;
  logic [ADDR_W-1:0]  recover_pc;
  logic [C_CNT_W-1:0] inflight_count;
  logic               resolve_err;

  modport master (
    output lookup_valid, lookup_pc, lookup_ckpt_pc, resolve_valid, resolve_data,
    input  lookup_ready, pred_valid, pred_data, recover, recover_pc,
           inflight_count, resolve_err
  );

  modport slave (
    input  lookup_valid, lookup_pc, lookup_ckpt_pc, resolve_valid, resolve_data,
    output lookup_ready, pred_valid, pred_data, recover, recover_pc,
           inflight_count, resolve_err
  );
endinterface
`default_nettype wire

// File: rtl/load_value_spec_unit.sv
`default_nettype none
// =============================================================================
// load_value_spec_unit : last-value load predictor with in-order miss tracking
// Rev 1.0
// =============================================================================
module load_value_spec_unit #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int ENTRIES      = 64,
  parameter int CONF_BITS    = 2,
  parameter int CONF_THRESH  = 2,
  parameter int MAX_INFLIGHT = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  load_value_spec_unit_if.slave bus
);
  localparam int C_IDX_W = $clog2(ENTRIES);
  localparam int C_TAG_W = ADDR_W - C_IDX_W - 2;
  localparam int C_PTR_W = $clog2(MAX_INFLIGHT);
  localparam int C_CNT_W = C_PTR_W + 1;
  localparam logic [CONF_BITS-1:0] C_CONF_MAX = {CONF_BITS{1'b1}};
  localparam logic [CONF_BITS-1:0] C_CONF_THR = CONF_BITS'(CONF_THRESH);
  localparam logic [C_CNT_W-1:0]   C_FULL     = C_CNT_W'(MAX_INFLIGHT);

  logic [ENTRIES-1:0]   tbl_valid_q, tbl_valid_d;
  logic [C_TAG_W-1:0]   tbl_tag_q   [ENTRIES];
  logic [DATA_W-1:0]    tbl_value_q [ENTRIES];
  logic [CONF_BITS-1:0] tbl_conf_q  [ENTRIES];

  logic [ADDR_W-1:0]    q_pc_q   [MAX_INFLIGHT];
  logic [ADDR_W-1:0]    q_ckpt_q [MAX_INFLIGHT];
  logic                 q_pred_q [MAX_INFLIGHT];
  logic [DATA_W-1:0]    q_pval_q [MAX_INFLIGHT];

  logic [C_PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [C_CNT_W-1:0]   count_q, count_d;
  logic                 pred_valid_q, pred_valid_d;
  logic [DATA_W-1:0]    pred_data_q, pred_data_d;
  logic                 recover_q, recover_d;
  logic [ADDR_W-1:0]    recover_pc_q, recover_pc_d;
  logic                 resolve_err_q, resolve_err_d;

  logic [C_IDX_W-1:0]   lk_idx, hd_idx;
  logic [C_TAG_W-1:0]   lk_tag, hd_tag;
  logic [ADDR_W-1:0]    hd_pc;
  logic                 lk_predicted, hd_hit;
  logic                 do_pop, mispredict, accept;
  logic [CONF_BITS-1:0] tbl_wconf;
  logic [DATA_W-1:0]    tbl_wvalue;
  logic                 w_unused;

  always_comb begin
    lk_idx       = bus.lookup_pc[C_IDX_W+1:2];
    lk_tag       = bus.lookup_pc[ADDR_W-1:C_IDX_W+2];
    lk_predicted = tbl_valid_q[lk_idx] && (tbl_tag_q[lk_idx] == lk_tag)
                   && (tbl_conf_q[lk_idx] >= C_CONF_THR);
    hd_pc        = q_pc_q[rd_ptr_q];
    hd_idx       = hd_pc[C_IDX_W+1:2];
    hd_tag       = hd_pc[ADDR_W-1:C_IDX_W+2];
    hd_hit       = tbl_valid_q[hd_idx] && (tbl_tag_q[hd_idx] == hd_tag);
    do_pop       = bus.resolve_valid && (count_q != '0);
    mispredict   = do_pop && q_pred_q[rd_ptr_q] && (bus.resolve_data != q_pval_q[rd_ptr_q]);
    // A mispredicting resolve flushes the queue, so a same-cycle lookup must not slip in.
    accept       = bus.lookup_valid && (count_q != C_FULL) && !recover_q && !mispredict;
  end

  // Training: a matching value strengthens confidence, anything else restarts at zero.
  always_comb begin
    tbl_valid_d = tbl_valid_q;
    tbl_wvalue  = bus.resolve_data;
    tbl_wconf   = '0;
    if (do_pop) begin
      tbl_valid_d[hd_idx] = 1'b1;
      if (hd_hit && (bus.resolve_data == tbl_value_q[hd_idx])) begin
        tbl_wconf = (tbl_conf_q[hd_idx] == C_CONF_MAX) ? C_CONF_MAX
                                                       : tbl_conf_q[hd_idx] + CONF_BITS'(1);
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (mispredict) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (accept) wr_ptr_d = wr_ptr_q + C_PTR_W'(1);
      if (do_pop) rd_ptr_d = rd_ptr_q + C_PTR_W'(1);
      if (accept && !do_pop)      count_d = count_q + C_CNT_W'(1);
      else if (!accept && do_pop) count_d = count_q - C_CNT_W'(1);
    end
    pred_valid_d  = accept && lk_predicted;
    pred_data_d   = (accept && lk_predicted) ? tbl_value_q[lk_idx] : '0;
    recover_d     = mispredict;
    recover_pc_d  = mispredict ? q_ckpt_q[rd_ptr_q] : '0;
    resolve_err_d = resolve_err_q || (bus.resolve_valid && (count_q == '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      pred_valid_q  <= 1'b0;
      pred_data_q   <= '0;
      recover_q     <= 1'b0;
      recover_pc_q  <= '0;
      resolve_err_q <= 1'b0;
    end else begin
      tbl_valid_q   <= tbl_valid_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      pred_valid_q  <= pred_valid_d;
      pred_data_q   <= pred_data_d;
      recover_q     <= recover_d;
      recover_pc_q  <= recover_pc_d;
      resolve_err_q <= resolve_err_d;
    end
  end

  // Payload storage needs no reset: entries are only read behind the valid bits / count.
  always_ff @(posedge clk) begin
    if (do_pop) begin
      tbl_tag_q[hd_idx]   <= hd_tag;
      tbl_value_q[hd_idx] <= tbl_wvalue;
      tbl_conf_q[hd_idx]  <= tbl_wconf;
    end
    if (accept) begin
      q_pc_q[wr_ptr_q]   <= bus.lookup_pc;
      q_ckpt_q[wr_ptr_q] <= bus.lookup_ckpt_pc;
      q_pred_q[wr_ptr_q] <= lk_predicted;
      q_pval_q[wr_ptr_q] <= lk_predicted ? tbl_value_q[lk_idx] : '0;
    end
  end

  assign bus.lookup_ready   = (count_q != C_FULL);
  assign bus.pred_valid     = pred_valid_q;
  assign bus.pred_data      = pred_data_q;
  assign bus.recover        = recover_q;
  assign bus.recover_pc     = recover_pc_q;
  assign bus.inflight_count = count_q;
  assign bus.resolve_err    = resolve_err_q;

  assign w_unused = ^{bus.lookup_pc[1:0], hd_pc[1:0]};
endmodule
`default_nettype wire

// File: tb/tb_load_value_spec_unit.sv
`default_nettype none
// Bench for load_value_spec_unit: directed scenarios plus random traffic, checked
// against a queue/array reference model through a scoreboard and output monitor.
module tb_load_value_spec_unit;
  localparam int ADDR_W       = 32;
  localparam int DATA_W       = 32;
  localparam int ENTRIES      = 64;
  localparam int CONF_BITS    = 2;
  localparam int CONF_THRESH  = 2;
  localparam int MAX_INFLIGHT = 4;
  localparam int CONF_MAX     = (1 << CONF_BITS) - 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  load_value_spec_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_INFLIGHT(MAX_INFLIGHT)) bus ();

  load_value_spec_unit #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ENTRIES(ENTRIES), .CONF_BITS(CONF_BITS),
    .CONF_THRESH(CONF_THRESH), .MAX_INFLIGHT(MAX_INFLIGHT)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] ckpt;
    bit                pred;
    logic [DATA_W-1:0] pval;
  } load_t;
  typedef struct {
    int          cyc;
    logic [63:0] val;
  } exp_t;

  // reference model state
  bit                m_valid [ENTRIES];
  int unsigned       m_tag   [ENTRIES];
  logic [DATA_W-1:0] m_value [ENTRIES];
  int                m_conf  [ENTRIES];
  load_t             m_q[$];
  bit                m_rec;
  bit                m_err;
  exp_t              sb_pred[$];
  exp_t              sb_rec[$];
  logic [DATA_W-1:0] truth [logic [ADDR_W-1:0]];
  logic [ADDR_W-1:0] pcs [6] = '{32'h100, 32'h200, 32'h104, 32'h300, 32'h404, 32'h108};

  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t mon_e;

  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int unsigned m_idx(logic [ADDR_W-1:0] pc);
    return (pc / 4) % ENTRIES;
  endfunction

  function automatic int unsigned m_tagof(logic [ADDR_W-1:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  function automatic void m_train(logic [ADDR_W-1:0] pc, logic [DATA_W-1:0] d);
    int unsigned i = m_idx(pc);
    if (m_valid[i] && m_tag[i] == m_tagof(pc)) begin
      if (d == m_value[i]) m_conf[i] = (m_conf[i] + 1 > CONF_MAX) ? CONF_MAX : m_conf[i] + 1;
      else begin m_value[i] = d; m_conf[i] = 0; end
    end else begin
      m_valid[i] = 1'b1; m_tag[i] = m_tagof(pc); m_value[i] = d; m_conf[i] = 0;
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_q.delete(); sb_pred.delete(); sb_rec.delete();
    m_rec = 1'b0; m_err = 1'b0;
  endfunction

  // Monitor: pops expectations whenever the DUT presents a prediction or a recover pulse.
  always @(negedge clk) if (rst_n) begin
    if (sb_pred.size() > 0 && sb_pred[0].cyc < cyc) begin
      mon_e = sb_pred.pop_front();
      check("pred_missing", 64'd0, 64'd1);
    end
    if (bus.pred_valid) begin
      if (sb_pred.size() == 0) check("pred_unexpected", bus.pred_valid, 64'd0);
      else begin
        mon_e = sb_pred.pop_front();
        check("pred_cycle", cyc, mon_e.cyc);
        check("pred_data", bus.pred_data, mon_e.val);
      end
    end else check("pred_data_idle", bus.pred_data, 64'd0);
    if (sb_rec.size() > 0 && sb_rec[0].cyc < cyc) begin
      mon_e = sb_rec.pop_front();
      check("recover_missing", 64'd0, 64'd1);
    end
    if (bus.recover) begin
      if (sb_rec.size() == 0) check("recover_unexpected", bus.recover, 64'd0);
      else begin
        mon_e = sb_rec.pop_front();
        check("recover_cycle", cyc, mon_e.cyc);
        check("recover_pc", bus.recover_pc, mon_e.val);
      end
    end else check("recover_pc_idle", bus.recover_pc, 64'd0);
  end

  // One cycle: check registered state against the model, advance the model, drive inputs.
  task automatic step(input bit lv, input logic [ADDR_W-1:0] lpc, input logic [ADDR_W-1:0] lckpt,
                      input bit rv, input logic [DATA_W-1:0] rd);
    int n;
    bit pop, mis, acc, pr;
    int unsigned i;
    load_t ent;
    check("inflight_count", bus.inflight_count, m_q.size());
    check("lookup_ready", bus.lookup_ready, (m_q.size() < MAX_INFLIGHT) ? 1 : 0);
    check("resolve_err", bus.resolve_err, m_err);
    check("recover_level", bus.recover, m_rec);
    n   = m_q.size();
    pop = rv && (n > 0);
    mis = pop && m_q[0].pred && (rd != m_q[0].pval);
    acc = lv && (n < MAX_INFLIGHT) && !m_rec && !mis;
    if (rv && n == 0) m_err = 1'b1;
    if (acc) begin
      i  = m_idx(lpc);
      pr = m_valid[i] && (m_tag[i] == m_tagof(lpc)) && (m_conf[i] >= CONF_THRESH);
      ent.pc = lpc; ent.ckpt = lckpt; ent.pred = pr;
      ent.pval = pr ? m_value[i] : '0;
      if (pr) sb_pred.push_back('{cyc: cyc + 1, val: 64'(m_value[i])});
    end
    if (pop) m_train(m_q[0].pc, rd);
    if (mis) begin
      sb_rec.push_back('{cyc: cyc + 1, val: 64'(m_q[0].ckpt)});
      m_q.delete();
    end else if (pop) void'(m_q.pop_front());
    if (acc) m_q.push_back(ent);
    m_rec = mis;
    bus.lookup_valid   = lv;
    bus.lookup_pc      = lpc;
    bus.lookup_ckpt_pc = lckpt;
    bus.resolve_valid  = rv;
    bus.resolve_data   = rd;
    @(negedge clk);
  endtask

  // Drops rst_n between clock edges and checks the outputs before any edge arrives.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    check({tag, "_recover"}, bus.recover, 64'd0);
    check({tag, "_count"}, bus.inflight_count, 64'd0);
    check({tag, "_ready"}, bus.lookup_ready, 64'd1);
    check({tag, "_pred_valid"}, bus.pred_valid, 64'd0);
    check({tag, "_recover_pc"}, bus.recover_pc, 64'd0);
    check({tag, "_err"}, bus.resolve_err, 64'd0);
    m_reset();
    bus.lookup_valid = 1'b0; bus.resolve_valid = 1'b0;
    #9 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] d;
    bit lv, rv;
    logic [ADDR_W-1:0] p;
    bus.lookup_valid = 1'b0; bus.lookup_pc = '0; bus.lookup_ckpt_pc = '0;
    bus.resolve_valid = 1'b0; bus.resolve_data = '0;
    m_reset();
    foreach (pcs[k]) truth[pcs[k]] = $urandom;
    #3;
    check("reset_pred_valid", bus.pred_valid, 64'd0);
    check("reset_pred_data", bus.pred_data, 64'd0);
    check("reset_ready", bus.lookup_ready, 64'd1);
    check("reset_count", bus.inflight_count, 64'd0);
    #9 rst_n = 1'b1;
    @(negedge clk);

    // cold predict
    for (int k = 0; k < 3; k++) begin
      step(1, 32'h100, 32'h0F0, 0, '0);
      step(0, '0, '0, 1, 32'hAB);
    end
    step(1, 32'h100, 32'h0F0, 0, '0);
    check("t1_pred_valid", bus.pred_valid, 64'd1);
    check("t1_pred_data", bus.pred_data, 64'hAB);
    step(0, '0, '0, 1, 32'hAB);

    // mispredict
    step(1, 32'h100, 32'h0F8, 0, '0);
    step(1, 32'h104, 32'h0FC, 0, '0);
    step(1, 32'h108, 32'h100, 0, '0);
    step(0, '0, '0, 1, 32'hCD);
    check("t2_recover", bus.recover, 64'd1);
    check("t2_recover_pc", bus.recover_pc, 64'h0F8);
    check("t2_count", bus.inflight_count, 64'd0);
    step(1, 32'h100, 32'h0F8, 0, '0);
    step(1, 32'h100, 32'h0F8, 0, '0);
    check("t2_pred_after", bus.pred_valid, 64'd0);
    step(0, '0, '0, 1, 32'hCD);

    // full queue
    for (int k = 0; k < 4; k++) step(1, 32'h200 + 32'(4 * k), 32'h1F0, 0, '0);
    check("t3_ready_full", bus.lookup_ready, 64'd0);
    step(1, 32'h210, 32'h1F0, 0, '0);
    check("t3_count_full", bus.inflight_count, 64'd4);
    step(0, '0, '0, 1, 32'h11);
    check("t3_ready_after", bus.lookup_ready, 64'd1);
    for (int k = 0; k < 3; k++) step(0, '0, '0, 1, 32'h12);

    // simultaneous lookup + resolve across pointer wrap
    step(1, 32'h300, 32'h2F0, 0, '0);
    step(1, 32'h304, 32'h2F0, 0, '0);
    for (int k = 0; k < 9; k++) begin
      d = m_q[0].pred ? m_q[0].pval : DATA_W'(k);
      step(1, 32'h300 + 32'(4 * (k % 4)), 32'h2F0, 1, d);
      check("t4_count", bus.inflight_count, 64'd2);
    end
    step(0, '0, '0, 1, m_q[0].pred ? m_q[0].pval : 32'h5);
    step(0, '0, '0, 1, m_q[0].pred ? m_q[0].pval : 32'h6);

    // empty resolve
    step(0, '0, '0, 1, 32'h55);
    check("t5_err", bus.resolve_err, 64'd1);
    check("t5_recover", bus.recover, 64'd0);
    step(1, 32'h100, 32'h0F8, 0, '0);

    // random traffic
    for (int k = 0; k < 1500; k++) begin
      lv = ($urandom_range(0, 9) < 6);
      rv = ($urandom_range(0, 9) < 4);
      p  = pcs[$urandom_range(0, 5)];
      if (m_q.size() > 0) begin
        if ($urandom_range(0, 19) == 0) truth[m_q[0].pc] = $urandom;
        d = ($urandom_range(0, 9) == 0) ? $urandom : truth[m_q[0].pc];
      end else d = $urandom;
      step(lv, p, p - 32'(4 * $urandom_range(1, 4)), rv, d);
    end

    // drain, then reset mid-recover and mid-occupancy
    for (int k = 0; k < 20 && m_q.size() > 0; k++) step(0, '0, '0, 1, truth[m_q[0].pc]);
    step(0, '0, '0, 0, '0);
    for (int k = 0; k < 3; k++) begin
      step(1, 32'h500, 32'h4F0, 0, '0);
      step(0, '0, '0, 1, 32'h77);
    end
    step(1, 32'h500, 32'h4F0, 0, '0);
    step(1, 32'h504, 32'h4F4, 0, '0);
    step(1, 32'h508, 32'h4F8, 0, '0);
    step(0, '0, '0, 1, 32'h99);
    check("t6_recover_pre", bus.recover, 64'd1);
    async_reset("t6a");
    for (int k = 0; k < 3; k++) step(1, 32'h100 + 32'(4 * k), 32'h0F0, 0, '0);
    check("t6_count_pre", bus.inflight_count, 64'd3);
    async_reset("t6b");
    for (int k = 0; k < 3; k++) step(0, '0, '0, 0, '0);
    check("sb_pred_drained", sb_pred.size(), 64'd0);
    check("sb_rec_drained", sb_rec.size(), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
